// File: rtl/jtframe_romslot_pkg.sv
// Shared types and constants for the Z80 ROM slot: FSM state encoding,
// the SDRAM word / CPU byte split and a byte-lane select helper.
package jtframe_romslot_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam int WORD_W   = 16;
    localparam int BYTE_W   = 8;
    localparam int BYTE_SEL = 0;

    function automatic logic [BYTE_W-1:0] selByte(input logic [WORD_W-1:0] word, input logic hi);
        return hi ? word[WORD_W-1:BYTE_W] : word[BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/jtframe_romslot_cache.sv
// Two-entry word cache for the ROM slot: tag/data/valid per entry, a
// round-robin replacement pointer, combinational hit lookup and one fill port.
module jtframe_romslot_cache
    import jtframe_romslot_pkg::*;
#(
    parameter int WAW = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [WAW-1:0]    i_lookupAddr,
    output logic              o_hit,
    output logic [WORD_W-1:0] o_hitWord,
    input  logic              i_fillWe,
    input  logic [WAW-1:0]    i_fillTag,
    input  logic [WORD_W-1:0] i_fillWord
);

    logic [WAW-1:0]    r_tag  [2];
    logic [WORD_W-1:0] r_data [2];
    logic [1:0]        r_valid;
    logic              r_ptr;
    logic              w_hit0;
    logic              w_hit1;

    // Valid bits and replacement pointer; clr wins over a coincident fill so a
    // word fetched from the old ROM image never becomes visible.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_valid <= 2'b00;
            r_ptr   <= 1'b0;
        end else if (i_fillWe) begin
            r_valid[r_ptr] <= 1'b1;
            r_ptr          <= ~r_ptr;
        end
    end

    // Tag and data storage need no reset; the valid bits gate every lookup.
    always_ff @(posedge clk) begin
        if (i_fillWe && !clr && !rst) begin
            r_tag[r_ptr]  <= i_fillTag;
            r_data[r_ptr] <= i_fillWord;
        end
    end

    // Lookup across both entries; entry 0 takes priority if both ever match.
    always_comb begin
        w_hit0    = r_valid[0] && (r_tag[0] == i_lookupAddr);
        w_hit1    = r_valid[1] && (r_tag[1] == i_lookupAddr);
        o_hit     = w_hit0 || w_hit1;
        o_hitWord = w_hit0 ? r_data[0] : r_data[1];
    end

endmodule

// File: rtl/jtframe_z80_romslot.sv
// ROM-side responder for the Z80 wait handshake. Serves CPU byte reads from
// a two-entry word cache and refills it from SDRAM over req/ack/dok.
module jtframe_z80_romslot
    import jtframe_romslot_pkg::*;
#(
    parameter int AW = 15,
    parameter int DW = 8,
    parameter int SW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic          addr_ok,
    output logic [DW-1:0] dout,
    output logic          data_ok,
    input  logic          clr,
    output logic [AW-2:0] sdram_addr,
    output logic          sdram_req,
    input  logic          sdram_ack,
    input  logic          sdram_dok,
    input  logic [SW-1:0] sdram_din
);

    localparam int WAW = AW - 1;

    state_t          r_state;
    state_t          w_nextState;
    logic            r_sdramReq;
    logic [WAW-1:0]  r_sdramAddr;
    logic            r_ok;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_dout;
    logic [WAW-1:0]  w_waddr;
    logic            w_cacheHit;
    logic            w_hit;
    logic [SW-1:0]   w_hitWord;
    logic            w_fill;

    assign w_waddr = addr[AW-1:1];
    assign w_hit   = addr_ok && w_cacheHit;
    assign w_fill  = (r_state == WAIT) && sdram_dok;

    jtframe_romslot_cache #(
        .WAW(WAW)
    ) u_cache (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .i_lookupAddr (w_waddr),
        .o_hit        (w_cacheHit),
        .o_hitWord    (w_hitWord),
        .i_fillWe     (w_fill),
        .i_fillTag    (r_sdramAddr),
        .i_fillWord   (sdram_din)
    );

    // Next-state logic: one outstanding request, IDLE only leaves on a miss.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (addr_ok && !w_cacheHit) w_nextState = REQ;
            REQ:     if (sdram_ack)              w_nextState = WAIT;
            WAIT:    if (sdram_dok)              w_nextState = IDLE;
            default:                             w_nextState = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    // SDRAM request: high exactly while in REQ, address frozen at the miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sdramReq  <= 1'b0;
            r_sdramAddr <= '0;
        end else begin
            r_sdramReq <= (w_nextState == REQ);
            if (r_state == IDLE && w_nextState == REQ) r_sdramAddr <= w_waddr;
        end
    end

    // Output register: captures the byte and the address it belongs to on a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ok   <= 1'b0;
            r_addr <= '0;
            r_dout <= '0;
        end else if (clr) begin
            r_ok <= 1'b0;
        end else if (w_hit) begin
            r_ok   <= 1'b1;
            r_addr <= addr;
            r_dout <= selByte(w_hitWord, addr[BYTE_SEL]);
        end else begin
            r_ok <= 1'b0;
        end
    end

    assign dout       = r_dout;
    assign data_ok    = r_ok && addr_ok && (addr == r_addr);
    assign sdram_req  = r_sdramReq;
    assign sdram_addr = r_sdramAddr;

endmodule

// File: doc/jtframe_z80_romslot.md
Name: jtframe_z80_romslot

Overview:
- ROM-side responder for the Z80 ROM wait handshake.
- Takes the CPU byte address and rom_cs from the CPU wrapper and returns the ROM byte with rom_ok (data_ok here).
- Fetches 16-bit words from the SDRAM controller over a req/ack/dok handshake.
- Holds a two-entry word cache so straight-line opcode fetches rarely stall the CPU.

Parameters:
- AW, 15, CPU byte address width; SDRAM word address is AW-1 bits.
- DW, 8, CPU data width; fixed at 8.
- SW, 16, SDRAM data width; fixed at 16; byte select from addr[0].

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- addr  in  AW  CPU byte address
- addr_ok  in  1  CPU chip select for ROM (rom_cs)
- dout  out  8  ROM byte to the CPU
- data_ok  out  1  dout valid for the current addr (rom_ok)
- clr  in  1  invalidate cache (ROM reloaded)
- sdram_addr  out  AW-1  word address to SDRAM
- sdram_req  out  1  request, held until ack
- sdram_ack  in  1  SDRAM accepted request
- sdram_dok  in  1  sdram_din valid, one-cycle pulse
- sdram_din  in  16  SDRAM word

Behaviour:
- Reset values:
  - state IDLE; valid[1:0]=0; replacement pointer=0.
  - sdram_req=0; sdram_addr=0; dout=0; data_ok=0.
- All state changes on rising clk only.
- Word address waddr = addr[AW-1:1]. Byte select: addr[0]=0 -> sdram word [7:0]; addr[0]=1 -> [15:8].
- Hit = addr_ok & valid[i] & tag[i]==waddr, for either entry.
- Output register:
  - On a hit, ok_r<=1, addr_r<=addr, dout<=selected byte.
  - Otherwise ok_r<=0.
- data_ok = ok_r & addr_ok & (addr==addr_r), combinational qualification. data_ok is never high for an address other than the one dout belongs to, and never high while addr_ok=0.
- Hit latency is 1 clk from addr presentation.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: addr_ok & !hit -> REQ; latch sdram_addr<=waddr; sdram_req<=1.
  - REQ: hold sdram_req=1 and sdram_addr stable. On sdram_ack=1: sdram_req<=0 next clk, go to WAIT.
  - WAIT: on sdram_dok=1, write tag/data into entry[ptr], set valid[ptr]=1, toggle ptr, go to IDLE.
- Miss latency = 1 (IDLE->REQ) + ack delay + dok delay + 1 (hit evaluation). With ack at the first REQ cycle and dok 3 clk later, data_ok rises 6 clk after addr presentation.
- addr changes or addr_ok drops during REQ/WAIT: the in-flight request still completes and fills the cache. Then IDLE re-evaluates the current addr.
- Only one outstanding SDRAM request; no new request leaves IDLE until the fill completes.
- sdram_dok outside WAIT is ignored. sdram_ack outside REQ is ignored.
- clr=1:
  - valid<=0 and ptr<=0; ok_r<=0.
  - If WAIT and dok coincide with clr, the fill is discarded (valid stays 0).
  - A fill completing after clr deasserts is written normally.
- Reset mid-transaction: FSM returns to IDLE and sdram_req drops next clk. A late dok is ignored.
- Both entries hit (cannot occur by construction): entry 0 wins.

Decomposition:
- Shared package jtframe_romslot_pkg:
  - state enum {IDLE, REQ, WAIT}
  - localparams for the word/byte split (SW, DW, BYTE_SEL bit)
- One sub-module, jtframe_romslot_cache: two tag/data/valid entries, replacement pointer, hit compare, fill write port, and clr. FSM and output register stay in the top module.

Test Plan:
- Cold miss:
  - Stimulus: reset, then addr=0x0010, addr_ok=1. SDRAM model acks on the first REQ cycle and pulses dok with sdram_din=0xBEEF 3 clk later.
  - Required: sdram_addr=0x0008; data_ok rises 6 clk after addr; dout=0xEF.
- Sequential hit:
  - Stimulus: after the cold miss, addr=0x0011.
  - Required: no sdram_req; data_ok=1 next clk; dout=0xBE.
- Replacement:
  - Stimulus: miss on words 0x0008, 0x0100, 0x0200 in turn, then revisit 0x0008.
  - Required: the 0x0200 fill evicts 0x0008 (round-robin); revisiting 0x0008 issues a new sdram_req.
- Address change mid-WAIT:
  - Stimulus: miss on 0x0040, then switch addr to 0x0080 before dok.
  - Required: data_ok stays 0 throughout; the 0x0020 word fills; then a request for word 0x0040 follows; data_ok rises only for 0x0080.
- Handshake hold:
  - Stimulus: delay sdram_ack 5 clk.
  - Required: sdram_req stays 1 and sdram_addr stays stable all 5 clk; req drops the clk after ack.
- clr and reset:
  - Stimulus 1: assert clr coincident with dok.
  - Required 1: no entry becomes valid; the next access misses.
  - Stimulus 2: assert rst during WAIT, then pulse dok.
  - Required 2: sdram_req=0, data_ok=0, cache empty, dok ignored.
